// File: rtl/gray_cnt_decoder_pkg.sv
// Shared definitions for the Gray-count receive side: FSM states,
// acquisition length and the Gray-to-binary decode used by the counters.
package gray_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Cycles spent filling the synchronizer before the first load.
    localparam int FILL_CYC = 2;

    // Widest Gray count the decode helper handles.
    localparam int GRAY_MAX_W = 32;

    // Zero-extended Gray in, binary out. Leading zeros decode to zeros,
    // so any narrower count can be widened, decoded and truncated.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_cnt_decoder_sync2.sv
// Two-flop synchronizer for a multi-bit Gray bus crossing into clk.
module gray_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Next values simply shift the foreign bus down the two-stage chain.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Both stages clear asynchronously so the first decode after reset is zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/gray_cnt_decoder.sv
// Consumer-side Gray count receiver: synchronizes, decodes to binary,
// verifies every change is a single +1 step and counts wrap-arounds.
module gray_cnt_decoder
    import gray_pkg::*;
#(
    parameter int N      = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      gr_in,
    input  logic              clr_err,
    output logic [N-1:0]      bin_out,
    output logic [N-2:0]      bin_n1_out,
    output logic              bin_valid,
    output logic              locked,
    output logic              step_err,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [N-1:0]      s2;
    logic [N-1:0]      b;
    logic [N-1:0]      bin_inc;
    logic              is_hold;
    logic              is_step;
    logic              fill_done;

    state_t            state_q, state_d;
    logic [1:0]        fill_q, fill_d;
    logic [N-1:0]      bin_q, bin_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              valid_q, valid_d;
    logic              step_err_q, step_err_d;

    gray_sync2 #(.W(N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gr_in),
        .q   (s2)
    );

    // Decode the synchronized count and classify it against the last good value.
    always_comb begin
        b         = N'(gray2bin(GRAY_MAX_W'(s2)));
        bin_inc   = bin_q + N'(1);
        is_hold   = (b == bin_q);
        is_step   = (b == bin_inc);
        fill_done = (fill_q == 2'(FILL_CYC));
    end

    // State register plus the registered datapath, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACQ;
            fill_q     <= '0;
            bin_q      <= '0;
            wrap_q     <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            bin_q      <= bin_d;
            wrap_q     <= wrap_d;
            valid_q    <= valid_d;
            step_err_q <= step_err_d;
        end
    end

    // Next-state logic: lock after the fill, drop to ERR on any bad step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQ:     if (fill_done) state_d = TRACK;
            TRACK:   if (!is_hold && !is_step) state_d = ERR;
            ERR:     if (clr_err) state_d = ACQ;
            default: state_d = ACQ;
        endcase
    end

    // Output logic: load/advance the binary count, wrap counter and pulses.
    always_comb begin
        fill_d     = fill_q;
        bin_d      = bin_q;
        wrap_d     = wrap_q;
        valid_d    = 1'b0;
        step_err_d = 1'b0;
        case (state_q)
            ACQ: begin
                if (fill_done) begin
                    bin_d   = b;
                    valid_d = 1'b1;
                    wrap_d  = '0;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 2'd1;
                end
            end
            TRACK: begin
                if (is_step) begin
                    bin_d   = b;
                    valid_d = 1'b1;
                    if ((&bin_q) && !(&wrap_q)) begin
                        wrap_d = wrap_q + WRAP_W'(1);
                    end
                end else if (!is_hold) begin
                    step_err_d = 1'b1;
                end
            end
            ERR: begin
                if (clr_err) begin
                    fill_d = '0;
                end
            end
            default: begin
                fill_d = '0;
            end
        endcase
    end

    assign bin_out    = bin_q;
    assign bin_n1_out = bin_q[N-2:0];
    assign bin_valid  = valid_q;
    assign step_err   = step_err_q;
    assign wrap_cnt   = wrap_q;
    assign locked     = (state_q == TRACK);
    assign err_sticky = (state_q == ERR);

endmodule

// File: tb/tb_gray_cnt_decoder.sv
// Directed bench for gray_cnt_decoder with N = 4, WRAP_W = 8.
module tb_gray_cnt_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] gr_in;
    logic       clr_err;
    logic [3:0] bin_out;
    logic [2:0] bin_n1_out;
    logic       bin_valid;
    logic       locked;
    logic       step_err;
    logic       err_sticky;
    logic [7:0] wrap_cnt;

    int checks;
    int errors;
    int valid_cnt;
    int serr_cnt;

    typedef struct {
        logic [3:0] gr;
        logic [3:0] bin;
        logic [2:0] n1;
    } vec_t;

    vec_t vecs[16];

    gray_cnt_decoder #(.N(4), .WRAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .gr_in      (gr_in),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_n1_out (bin_n1_out),
        .bin_valid  (bin_valid),
        .locked     (locked),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .wrap_cnt   (wrap_cnt)
    );

    // Free-running consumer clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] toGray(input int v);
        logic [3:0] x;
        x = 4'(v);
        return x ^ (x >> 1);
    endfunction

    task automatic applyStimulus(input logic [3:0] g, input logic c);
        gr_in   = g;
        clr_err = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
        if (bin_valid === 1'b1) valid_cnt++;
        if (step_err === 1'b1) serr_cnt++;
    endtask

    task automatic stepTo(input logic [3:0] g);
        applyStimulus(g, 1'b0);
        waitCycle();
        waitCycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " bin_out"},    32'(bin_out),    0);
        checkOutput({tag, " bin_n1_out"}, 32'(bin_n1_out), 0);
        checkOutput({tag, " bin_valid"},  32'(bin_valid),  0);
        checkOutput({tag, " locked"},     32'(locked),     0);
        checkOutput({tag, " step_err"},   32'(step_err),   0);
        checkOutput({tag, " err_sticky"}, 32'(err_sticky), 0);
        checkOutput({tag, " wrap_cnt"},   32'(wrap_cnt),   0);
    endtask

    initial begin
        int vsave;

        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        serr_cnt  = 0;

        vecs[0]  = '{4'b0001, 4'd1,  3'd1};
        vecs[1]  = '{4'b0011, 4'd2,  3'd2};
        vecs[2]  = '{4'b0010, 4'd3,  3'd3};
        vecs[3]  = '{4'b0110, 4'd4,  3'd4};
        vecs[4]  = '{4'b0111, 4'd5,  3'd5};
        vecs[5]  = '{4'b0101, 4'd6,  3'd6};
        vecs[6]  = '{4'b0100, 4'd7,  3'd7};
        vecs[7]  = '{4'b1100, 4'd8,  3'd0};
        vecs[8]  = '{4'b1101, 4'd9,  3'd1};
        vecs[9]  = '{4'b1111, 4'd10, 3'd2};
        vecs[10] = '{4'b1110, 4'd11, 3'd3};
        vecs[11] = '{4'b1010, 4'd12, 3'd4};
        vecs[12] = '{4'b1011, 4'd13, 3'd5};
        vecs[13] = '{4'b1001, 4'd14, 3'd6};
        vecs[14] = '{4'b1000, 4'd15, 3'd7};
        vecs[15] = '{4'b0000, 4'd0,  3'd0};

        // Reset values while rst is held low.
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");

        // Release and acquire: lock on the third edge.
        rst = 1'b1;
        waitCycle();
        waitCycle();
        checkOutput("acq locked before 3rd edge", 32'(locked), 0);
        waitCycle();
        checkOutput("acq locked",    32'(locked),    1);
        checkOutput("acq bin_valid", 32'(bin_valid), 1);
        checkOutput("acq bin_out",   32'(bin_out),   0);
        checkOutput("acq wrap_cnt",  32'(wrap_cnt),  0);
        waitCycle();
        checkOutput("acq bin_valid pulse ends", 32'(bin_valid), 0);
        valid_cnt = 0;

        // Full Gray sequence, one step per two cycles.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].gr, 1'b0);
            waitCycle();
            if (i > 0) begin
                checkOutput($sformatf("seq bin_out[%0d]", i - 1),    32'(bin_out),    32'(vecs[i-1].bin));
                checkOutput($sformatf("seq bin_n1_out[%0d]", i - 1), 32'(bin_n1_out), 32'(vecs[i-1].n1));
            end
            waitCycle();
        end
        waitCycle();
        checkOutput("seq bin_out last",    32'(bin_out),    0);
        checkOutput("seq bin_n1_out last", 32'(bin_n1_out), 0);
        waitCycle();
        checkOutput("seq valid pulses", 32'(valid_cnt), 16);
        checkOutput("seq wrap_cnt",     32'(wrap_cnt),  1);
        checkOutput("seq step_err cnt", 32'(serr_cnt),  0);

        // Walk to bin 5, take three legal steps, then jump by two.
        for (int v = 1; v <= 5; v++) stepTo(toGray(v));
        waitCycle();
        waitCycle();
        checkOutput("jump start bin_out", 32'(bin_out), 5);
        stepTo(4'b0101);
        stepTo(4'b0100);
        stepTo(4'b1100);
        applyStimulus(4'b1111, 1'b0);
        waitCycle();
        checkOutput("jump bin_out 8", 32'(bin_out), 8);
        waitCycle();
        waitCycle();
        checkOutput("jump step_err",   32'(step_err),   1);
        checkOutput("jump err_sticky", 32'(err_sticky), 1);
        checkOutput("jump locked",     32'(locked),     0);
        checkOutput("jump bin_out",    32'(bin_out),    8);
        checkOutput("jump serr count", 32'(serr_cnt),   1);
        waitCycle();
        checkOutput("jump step_err pulse ends", 32'(step_err),   0);
        checkOutput("jump err_sticky holds",    32'(err_sticky), 1);

        // Toggle gr_in in ERR: no further pulses, outputs frozen.
        vsave = valid_cnt;
        stepTo(4'b0000);
        stepTo(4'b0110);
        stepTo(4'b1010);
        waitCycle();
        checkOutput("err serr count", 32'(serr_cnt),  1);
        checkOutput("err bin_out",    32'(bin_out),   8);
        checkOutput("err no valid",   32'(valid_cnt), vsave);
        checkOutput("err sticky",     32'(err_sticky), 1);

        // Clear together with a new value; reacquire three edges later.
        applyStimulus(4'b0011, 1'b1);
        waitCycle();
        applyStimulus(4'b0011, 1'b0);
        checkOutput("clr err_sticky", 32'(err_sticky), 0);
        checkOutput("clr locked",     32'(locked),     0);
        waitCycle();
        waitCycle();
        checkOutput("clr locked before load", 32'(locked), 0);
        waitCycle();
        checkOutput("clr bin_out",    32'(bin_out),    2);
        checkOutput("clr locked now", 32'(locked),     1);
        checkOutput("clr bin_valid",  32'(bin_valid),  1);
        checkOutput("clr wrap_cnt",   32'(wrap_cnt),   0);

        // 300 wraps at one step per cycle; wrap_cnt saturates at 255.
        for (int w = 0; w < 300; w++) begin
            for (int k = 1; k <= 16; k++) begin
                applyStimulus(toGray((2 + k) % 16), 1'b0);
                waitCycle();
            end
            if (w == 9 || w == 254) begin
                repeat (3) waitCycle();
                checkOutput($sformatf("wrap_cnt after %0d wraps", w + 1), 32'(wrap_cnt), 32'(w + 1));
            end
        end
        repeat (3) waitCycle();
        checkOutput("wrap saturated",  32'(wrap_cnt), 255);
        checkOutput("wrap bin_out",    32'(bin_out),  2);
        checkOutput("wrap serr count", 32'(serr_cnt), 1);
        checkOutput("wrap locked",     32'(locked),   1);

        // Asynchronous reset mid-TRACK at bin 9.
        for (int v = 3; v <= 9; v++) stepTo(toGray(v));
        waitCycle();
        waitCycle();
        checkOutput("pre-reset bin_out", 32'(bin_out), 9);
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        waitCycle();
        rst = 1'b1;
        waitCycle();
        waitCycle();
        checkOutput("rerelease locked early", 32'(locked), 0);
        waitCycle();
        checkOutput("rerelease bin_out", 32'(bin_out), 9);
        checkOutput("rerelease locked",  32'(locked),  1);
        checkOutput("rerelease wrap",    32'(wrap_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_cnt_decoder.md
# gray_cnt_decoder

Receive-side companion for the dual Gray counters: samples an N-bit Gray count driven from another clock domain and synchronizes it through two flops. It decodes the count to binary, along with the derived (N-1)-bit count, and checks that every observed change is a legal +1 Gray step. It also counts wrap-arounds and raises a sticky error on any illegal transition. It sits in the consumer clock domain of a Gray-pointer crossing, for example the read side of a pointer handoff.

## Interface
- N, 4, width of incoming Gray count (N ≥ 2)
- WRAP_W, 8, width of wrap counter
- clk  in  1  consumer-domain clock
- rst  in  1  reset, asynchronous, active-low
- gr_in  in  N  Gray count from foreign domain, asynchronous to clk
- clr_err  in  1  single-cycle pulse; clears ERR state and restarts acquisition
- bin_out  out  N  decoded binary of the synchronized N-bit count (registered)
- bin_n1_out  out  N-1  decoded binary of the derived (N-1)-bit Gray count; equals bin_out[N-2:0]
- bin_valid  out  1  one-cycle pulse when bin_out takes a new value
- locked  out  1  high in TRACK
- step_err  out  1  one-cycle pulse on an illegal transition
- err_sticky  out  1  high in ERR
- wrap_cnt  out  WRAP_W  number of all-ones→zero wraps seen since lock; saturating

## Operation
- Synchronizer: s1 <= gr_in; s2 <= s1. Both reset to 0.
- Decode (combinational on s2): b[N-1] = s2[N-1]; b[i] = b[i+1] ^ s2[i].
- bin_n1_out uses the same decode.
  - The (N-1)-bit Gray code is {g[N-1]^g[N-2], g[N-3:0]}, and its binary equals b[N-2:0].
  - No separate decoder is needed for it.
- FSM states: ACQ, TRACK, ERR. Reset state is ACQ.
- ACQ
  - A 2-bit fill counter counts cycles after reset release or clear.
  - When fill == 2: bin_out <= b, bin_valid = 1, wrap_cnt <= 0, go to TRACK.
  - Before that, bin_out holds its current value.
- TRACK, comparing b against bin_out every cycle:
  - b == bin_out: hold, no pulse.
  - b == bin_out + 1 (mod 2^N): bin_out <= b, bin_valid = 1.
    - If bin_out was all-ones, wrap_cnt increments, saturating at 2^WRAP_W − 1.
  - Any other value: step_err = 1, go to ERR, bin_out holds its last good value.
- ERR
  - err_sticky = 1; outputs are frozen.
  - New gr_in changes do not produce further step_err pulses.
  - clr_err → ACQ, with the fill counter cleared.
- clr_err in ACQ or TRACK is ignored.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.

## Timing
- Reset values: bin_out = 0, bin_n1_out = 0, bin_valid = 0, locked = 0, step_err = 0, err_sticky = 0, wrap_cnt = 0, state = ACQ.
- Latency: a value stable on gr_in before edge k is in s1 after edge k and in s2 after k+1. bin_out and bin_valid update at edge k+2.
- After reset release, the first acquisition load occurs on the third rising edge, and locked rises at the same edge.
- bin_valid, step_err: exactly one cycle, registered.
- The check runs every cycle. A source advancing faster than one step per clk cycle appears as a multi-step jump and is flagged as step_err by design.
- Simultaneous clr_err and a new gr_in value while in ERR: move to ACQ. The value is picked up during acquisition.

## Structure
- Package gray_pkg holds:
  - typedef of FSM enum state_t {ACQ, TRACK, ERR}
  - constant FILL_CYC = 2
  - function gray2bin(N-bit), shared with existing counter code
- Sub-module gray_sync2: a parameterized 2-flop synchronizer (width N, asynchronous active-low reset). It is reusable by other crossings.
- Top level contains the decode, FSM, step comparator and wrap counter.

## Test plan
- Reset then hold gr_in = 4'b0000 → locked = 1 at the 3rd edge; bin_out = 0; one bin_valid pulse; wrap_cnt = 0.
- Drive the full 4-bit Gray sequence, one step per 2 clk cycles, 16 steps, 0000→…→1000→0000.
  - bin_out runs 0..15 then 0.
  - bin_n1_out runs 0..7, 0..7.
  - 16 bin_valid pulses after lock; wrap_cnt = 1; no step_err.
- While locked at bin 5 (Gray 0111), jump gr_in to 0101 (bin 6, legal) then 0100 (bin 7, legal), then 1100 (bin 8, legal), then 1111 (bin 10).
  - The first three steps are legal.
  - The last jump gives step_err for one cycle, err_sticky = 1, bin_out frozen at 8.
- In ERR, toggle gr_in, then pulse clr_err with gr_in = 0011 (bin 2) → ACQ; after 3 edges, bin_out = 2, locked = 1, err_sticky = 0.
- Run 300 wraps with WRAP_W = 8 → wrap_cnt saturates at 255.
- Assert rst low mid-TRACK at bin 9 → all outputs are 0 immediately. After release with gr_in = 1101 (bin 9), bin_out = 9 after 3 edges.
